// File: rtl/mod_updown_counter.sv
// Up/down/load counter with wrap or saturate, clock-enable prescaler, and registered status flags.
// Count changes one cycle after a tick or load edge; there is no backpressure, and En=0 freezes all state.
module mod_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MODULUS   = 256,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Sat,
  output logic [WIDTH-1:0] Count,
  output logic             TC,
  output logic             Zero,
  output logic             AtMax,
  output logic             SatFlag
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [PS_W-1:0]  ps;
  logic [PS_W-1:0]  ps_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             sat_nxt;

  // Limits are compared at WIDTH bits, so a full-range modulus never relies on overflow.
  always_comb begin
    count_nxt = Count;
    ps_nxt    = ps;
    tc_nxt    = 1'b0;
    sat_nxt   = SatFlag;
    if (En) begin
      case (Mode)
        MODE_LOAD: begin
          count_nxt = (LoadVal > MAX_VAL) ? MAX_VAL : LoadVal;
          ps_nxt    = '0;
          sat_nxt   = 1'b0;
        end
        MODE_UP, MODE_DOWN: begin
          if (ps == PS_LAST) begin
            ps_nxt = '0;
            if (Mode == MODE_UP) begin
              if (Count != MAX_VAL) begin
                count_nxt = Count + WIDTH'(1);
              end else if (Sat) begin
                sat_nxt = 1'b1;
              end else begin
                count_nxt = '0;
                tc_nxt    = 1'b1;
              end
            end else begin
              if (Count != '0) begin
                count_nxt = Count - WIDTH'(1);
              end else if (Sat) begin
                sat_nxt = 1'b1;
              end else begin
                count_nxt = MAX_VAL;
                tc_nxt    = 1'b1;
              end
            end
          end else begin
            ps_nxt = ps + PS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Flags decode the next count so they line up with Count on the same cycle.
  always_ff @(posedge Clk) begin
    if (reset) begin
      Count   <= RST_VAL;
      ps      <= '0;
      TC      <= 1'b0;
      SatFlag <= 1'b0;
      Zero    <= (RST_VAL == '0);
      AtMax   <= (RST_VAL == MAX_VAL);
    end else begin
      Count   <= count_nxt;
      ps      <= ps_nxt;
      TC      <= tc_nxt;
      SatFlag <= sat_nxt;
      Zero    <= (count_nxt == '0);
      AtMax   <= (count_nxt == MAX_VAL);
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: four instances with different modulus/prescale/reset settings.
module tb_mod_updown_counter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst   [4];
  logic       en    [4];
  logic       sat   [4];
  logic [1:0] mode  [4];
  logic [7:0] ld    [4];
  logic [7:0] cnt   [4];
  logic       tc    [4];
  logic       zero  [4];
  logic       atmax [4];
  logic       satf  [4];

  mod_updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1), .RESET_VAL(0)) u_full (
    .Clk(Clk), .reset(rst[0]), .En(en[0]), .Mode(mode[0]), .LoadVal(ld[0]), .Sat(sat[0]),
    .Count(cnt[0]), .TC(tc[0]), .Zero(zero[0]), .AtMax(atmax[0]), .SatFlag(satf[0]));

  mod_updown_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .RESET_VAL(5)) u_mod10 (
    .Clk(Clk), .reset(rst[1]), .En(en[1]), .Mode(mode[1]), .LoadVal(ld[1]), .Sat(sat[1]),
    .Count(cnt[1]), .TC(tc[1]), .Zero(zero[1]), .AtMax(atmax[1]), .SatFlag(satf[1]));

  mod_updown_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(4), .RESET_VAL(0)) u_ps4 (
    .Clk(Clk), .reset(rst[2]), .En(en[2]), .Mode(mode[2]), .LoadVal(ld[2]), .Sat(sat[2]),
    .Count(cnt[2]), .TC(tc[2]), .Zero(zero[2]), .AtMax(atmax[2]), .SatFlag(satf[2]));

  mod_updown_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(3), .RESET_VAL(2)) u_ps3 (
    .Clk(Clk), .reset(rst[3]), .En(en[3]), .Mode(mode[3]), .LoadVal(ld[3]), .Sat(sat[3]),
    .Count(cnt[3]), .TC(tc[3]), .Zero(zero[3]), .AtMax(atmax[3]), .SatFlag(satf[3]));

  typedef struct {
    int         cyc;
    int         dut;
    logic [7:0] count;
    logic       tc;
    logic       sf;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] dn_seq [11] = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd9};

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int mod_of(input int d);
    return (d == 0) ? 256 : 10;
  endfunction

  function automatic logic [7:0] rv_of(input int d);
    return (d == 1) ? 8'd5 : (d == 3) ? 8'd2 : 8'd0;
  endfunction

  // Expected state after the next rising edge.
  task automatic expect_next(input int d, input logic [7:0] c, input logic t, input logic s);
    exp_t e;
    e.cyc   = cyc + 1;
    e.dut   = d;
    e.count = c;
    e.tc    = t;
    e.sf    = s;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        logic zw;
        logic aw;
        e  = sb.pop_front();
        zw = (e.count == 8'd0);
        aw = (e.count == 8'(mod_of(e.dut) - 1));
        checks++;
        if (e.cyc != cyc || cnt[e.dut] != e.count || tc[e.dut] != e.tc || zero[e.dut] != zw ||
            atmax[e.dut] != aw || satf[e.dut] != e.sf) begin
          errors++;
          $display("FAIL dut%0d cyc%0d (due %0d): got cnt=%0d tc=%b zero=%b atmax=%b sat=%b, want cnt=%0d tc=%b zero=%b atmax=%b sat=%b",
                   e.dut, cyc, e.cyc, cnt[e.dut], tc[e.dut], zero[e.dut], atmax[e.dut], satf[e.dut],
                   e.count, e.tc, zw, aw, e.sf);
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 4; d++) begin
      rst[d]  = 1'b1;
      en[d]   = 1'b0;
      sat[d]  = 1'b0;
      mode[d] = 2'b00;
      ld[d]   = 8'd0;
    end
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) expect_next(d, rv_of(d), 1'b0, 1'b0);
      step();
    end
    for (int d = 0; d < 4; d++) rst[d] = 1'b0;

    // Full-range up count with a single wrap at 255 -> 0.
    en[0]   = 1'b1;
    mode[0] = 2'b01;
    for (int i = 1; i <= 300; i++) begin
      expect_next(0, 8'(i % 256), (i == 256), 1'b0);
      step();
    end
    en[0] = 1'b0;
    expect_next(0, 8'd44, 1'b0, 1'b0);
    step();

    // Modulo-10 down count with wrap from 0 to 9.
    en[1]   = 1'b1;
    mode[1] = 2'b11;
    ld[1]   = 8'd0;
    expect_next(1, 8'd0, 1'b0, 1'b0);
    step();
    mode[1] = 2'b10;
    for (int i = 0; i < 11; i++) begin
      expect_next(1, dn_seq[i], (i == 0 || i == 10), 1'b0);
      step();
    end

    // Saturation at the top and at zero, cleared by load.
    sat[1]  = 1'b1;
    mode[1] = 2'b11;
    ld[1]   = 8'd8;
    expect_next(1, 8'd8, 1'b0, 1'b0);
    step();
    mode[1] = 2'b01;
    expect_next(1, 8'd9, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      expect_next(1, 8'd9, 1'b0, 1'b1);
      step();
    end
    mode[1] = 2'b11;
    ld[1]   = 8'd3;
    expect_next(1, 8'd3, 1'b0, 1'b0);
    step();
    ld[1] = 8'd0;
    expect_next(1, 8'd0, 1'b0, 1'b0);
    step();
    mode[1] = 2'b10;
    expect_next(1, 8'd0, 1'b0, 1'b1);
    step();
    sat[1] = 1'b0;

    // Load clamp, reset priority over load, load ignored without enable, hold.
    mode[1] = 2'b11;
    ld[1]   = 8'd200;
    expect_next(1, 8'd9, 1'b0, 1'b0);
    step();
    ld[1] = 8'd10;
    expect_next(1, 8'd9, 1'b0, 1'b0);
    step();
    ld[1]  = 8'd200;
    rst[1] = 1'b1;
    expect_next(1, 8'd5, 1'b0, 1'b0);
    step();
    rst[1] = 1'b0;
    en[1]  = 1'b0;
    ld[1]  = 8'd1;
    expect_next(1, 8'd5, 1'b0, 1'b0);
    step();
    en[1]   = 1'b1;
    mode[1] = 2'b00;
    expect_next(1, 8'd5, 1'b0, 1'b0);
    step();
    en[1] = 1'b0;

    // Prescale 4 with an enable gap, then up/down switching keeps the phase.
    en[2]   = 1'b1;
    mode[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      expect_next(2, 8'd0, 1'b0, 1'b0);
      step();
    end
    en[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_next(2, 8'd0, 1'b0, 1'b0);
      step();
    end
    en[2] = 1'b1;
    expect_next(2, 8'd1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      expect_next(2, 8'd1, 1'b0, 1'b0);
      step();
    end
    expect_next(2, 8'd2, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      expect_next(2, 8'd2, 1'b0, 1'b0);
      step();
    end
    mode[2] = 2'b10;
    expect_next(2, 8'd2, 1'b0, 1'b0);
    step();
    expect_next(2, 8'd1, 1'b0, 1'b0);
    step();
    en[2] = 1'b0;

    // Prescale 3: saturate, then reset mid-phase clears flag and phase.
    en[3]   = 1'b1;
    sat[3]  = 1'b1;
    mode[3] = 2'b11;
    ld[3]   = 8'd9;
    expect_next(3, 8'd9, 1'b0, 1'b0);
    step();
    mode[3] = 2'b01;
    expect_next(3, 8'd9, 1'b0, 1'b0);
    step();
    expect_next(3, 8'd9, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      expect_next(3, 8'd9, 1'b0, 1'b1);
      step();
    end
    rst[3] = 1'b1;
    expect_next(3, 8'd2, 1'b0, 1'b0);
    step();
    rst[3] = 1'b0;
    sat[3] = 1'b0;
    expect_next(3, 8'd2, 1'b0, 1'b0);
    step();
    expect_next(3, 8'd2, 1'b0, 1'b0);
    step();
    expect_next(3, 8'd3, 1'b0, 1'b0);
    step();
    en[3] = 1'b0;

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
